fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC generation, synchronous imem addressing and the IF/EX register.
// One edge from address to imem_rdata, one more into IF/EX; stall_FETCH freezes PC and IF/EX, redirect inserts one bubble.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_FETCH,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_EX,
  output logic [31:0] pc_EX,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [11:0] csr,
  output logic        stall_EX,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {FILL, RUN} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bubble;
  } ifex_t;

  state_t      state;
  logic        fvalid;
  logic [31:0] pc_F;
  logic [31:0] pc_req;
  ifex_t       ifex;
  logic        unused_bits;

  // imem_rdata is only meaningful once the first address has been issued after reset
  assign fvalid = (state == RUN);

  always_comb begin
    pc_req = pc_F + 32'd4;
    if (redirect)
      pc_req = {redirect_pc[31:2], 2'b00};
    else if (!fvalid || stall_FETCH)
      pc_req = pc_F;
  end

  // Reset must win over a redirect still asserted on the input
  assign imem_addr = rst ? 12'd0 : pc_req[13:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      pc_F    <= 32'd0;
      ifex    <= '{instr: NOP, pc: 32'd0, bubble: 1'b1};
      instret <= 32'd0;
    end else begin
      state <= RUN;
      pc_F  <= pc_req;
      // The instruction in EX retires even when it is the redirecting branch
      if (!ifex.bubble && !stall_FETCH)
        instret <= instret + 32'd1;
      if (redirect || !fvalid)
        ifex <= '{instr: NOP, pc: pc_F, bubble: 1'b1};
      else if (!stall_FETCH)
        ifex <= '{instr: imem_rdata, pc: pc_F, bubble: 1'b0};
    end
  end

  assign instr_EX = ifex.instr;
  assign pc_EX    = ifex.pc;
  assign stall_EX = ifex.bubble;

  assign opcode = ifex.instr[6:0];
  assign funct3 = ifex.instr[14:12];
  assign funct7 = ifex.instr[31:25];
  assign csr    = ifex.instr[31:20];

  assign unused_bits = ^{redirect_pc[1:0], pc_req[31:14], pc_req[1:0]};

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a cycle-level reference that reads program memory directly.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_FETCH;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_EX;
  logic [31:0] pc_EX;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] csr;
  logic        stall_EX;
  logic [31:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [4096];

  // Reference state: fetch PC, whether a word is in flight, expected IF/EX contents, retired count
  logic [31:0] m_pc;
  logic        m_fv;
  logic [31:0] m_instr;
  logic [31:0] m_pcex;
  logic        m_bub;
  logic [31:0] m_ret;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall_FETCH (stall_FETCH),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_EX    (instr_EX),
    .pc_EX       (pc_EX),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .csr         (csr),
    .stall_EX    (stall_EX),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_fetch_pc();
    if (redirect)               return redirect_pc & 32'hFFFF_FFFC;
    if (!m_fv || stall_FETCH)   return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_fv = 0; m_instr = NOP; m_pcex = 0; m_bub = 1; m_ret = 0;
  endtask

  task automatic model_edge();
    logic [31:0] nxt;
    nxt = next_fetch_pc();
    if (!m_bub && !stall_FETCH) m_ret = m_ret + 1;
    if (redirect || !m_fv) begin
      m_instr = NOP; m_pcex = m_pc; m_bub = 1;
    end else if (!stall_FETCH) begin
      m_instr = mem[m_pc[13:2]]; m_pcex = m_pc; m_bub = 0;
    end
    m_pc = nxt;
    m_fv = 1;
  endtask

  task automatic check_outputs();
    chk("instr_EX", instr_EX, m_instr);
    chk("pc_EX", pc_EX, m_pcex);
    chk("stall_EX", {31'b0, stall_EX}, {31'b0, m_bub});
    chk("instret", instret, m_ret);
    chk("decode", {3'b0, opcode, funct3, funct7, csr},
        {3'b0, m_instr[6:0], m_instr[14:12], m_instr[31:25], m_instr[31:20]});
  endtask

  // Called just after a rising edge with inputs already set for the coming cycle
  task automatic step();
    logic [31:0] req;
    @(negedge clk);
    req = next_fetch_pc();
    chk("imem_addr", {20'b0, imem_addr}, {20'b0, req[13:2]});
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values();
    chk("rst_instr", instr_EX, NOP);
    chk("rst_pc_EX", pc_EX, 32'd0);
    chk("rst_stall_EX", {31'b0, stall_EX}, 32'd1);
    chk("rst_instret", instret, 32'd0);
    chk("rst_imem_addr", {20'b0, imem_addr}, 32'd0);
  endtask

  task automatic boot_sequence();
    logic [31:0] exp_instr [4];
    logic [31:0] exp_pc [4];
    exp_instr = '{NOP, mem[0], mem[1], mem[2]};
    exp_pc    = '{32'h0, 32'h0, 32'h4, 32'h8};
    for (int e = 0; e < 4; e++) begin
      chk("boot_addr", {20'b0, imem_addr}, e);
      step();
      chk("boot_instr", instr_EX, exp_instr[e]);
      chk("boot_pc", pc_EX, exp_pc[e]);
    end
  endtask

  initial begin
    logic [31:0] ret_before;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[0] = 32'h00500093; mem[1] = 32'h00a00113; mem[2] = 32'h002081b3; mem[3] = 32'h40208233;

    rst = 1; stall_FETCH = 0; redirect = 0; redirect_pc = 0;
    model_reset();
    #3;
    check_reset_values();
    @(posedge clk); #1;
    rst = 0;
    #1;
    boot_sequence();

    // Advance until the fetch PC reaches 0x10, then freeze for three cycles
    for (int g = 0; g < 20 && m_pc != 32'h10; g++) step();
    chk("reach_0x10", m_pc, 32'h10);
    stall_FETCH = 1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_addr", {20'b0, imem_addr}, 32'd4);
      step();
    end
    stall_FETCH = 0;
    step();
    chk("resume_pc", pc_EX, 32'h10);
    chk("resume_instr", instr_EX, mem[4]);

    for (int g = 0; g < 20 && m_pc != 32'h20; g++) step();
    redirect = 1; redirect_pc = 32'h103;
    #1;
    chk("redir_addr", {20'b0, imem_addr}, 32'h40);
    step();
    redirect = 0;
    chk("redir_bubble", {31'b0, stall_EX}, 32'd1);
    step();
    chk("redir_pc", pc_EX, 32'h100);
    chk("redir_instr", instr_EX, mem[64]);

    // Redirect and stall together: redirect wins, EX instruction does not retire
    ret_before = instret;
    redirect = 1; stall_FETCH = 1; redirect_pc = 32'h200;
    step();
    redirect = 0; stall_FETCH = 0;
    chk("rs_bubble", {31'b0, stall_EX}, 32'd1);
    chk("rs_instret", instret, ret_before);
    chk("rs_pcF", m_pc, 32'h200);
    step();
    chk("rs_target", pc_EX, 32'h200);

    redirect = 1; redirect_pc = 32'hFFFF_FFFE;
    #1;
    chk("wrap_addr_fff", {20'b0, imem_addr}, 32'hFFF);
    step();
    redirect = 0;
    #1;
    chk("wrap_addr_000", {20'b0, imem_addr}, 32'h0);
    step();
    chk("wrap_pc_top", pc_EX, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc_zero", pc_EX, 32'h0);

    for (int c = 0; c < 400; c++) begin
      stall_FETCH = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      step();
    end

    // Asynchronous reset mid-cycle while a redirect is being requested
    redirect = 1; redirect_pc = 32'h0000_0abc; stall_FETCH = 1;
    @(posedge clk); #2;
    rst = 1;
    model_reset();
    #1;
    check_reset_values();
    redirect = 0; stall_FETCH = 0; redirect_pc = 0;
    @(posedge clk); #1;
    check_reset_values();
    rst = 0;
    #1;
    boot_sequence();
    for (int c = 0; c < 20; c++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
